// File: rtl/instr_register_alu.sv
`default_nettype none
// ============================================================================
// Module   : instr_register_alu
// Brief    : Instruction register that computes and stores each instruction's
//            signed result at write time, with per-slot valid/err flags.
// Revision : 1.0 - initial release
// ============================================================================
module instr_register_alu #(
    parameter int OP_W     = 32,
    parameter int DEPTH    = 32,
    parameter int AUTO_INC = 1,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_en,
    input  logic [2:0]          opcode,
    input  logic [OP_W-1:0]     operand_a,
    input  logic [OP_W-1:0]     operand_b,
    input  logic [PTR_W-1:0]    write_pointer,
    input  logic [PTR_W-1:0]    read_pointer,
    output logic [2:0]          rd_opcode,
    output logic [OP_W-1:0]     rd_operand_a,
    output logic [OP_W-1:0]     rd_operand_b,
    output logic [2*OP_W-1:0]   rd_result,
    output logic                rd_valid,
    output logic                rd_err,
    output logic [PTR_W-1:0]    wr_ptr,
    output logic [PTR_W:0]      count,
    output logic                full
);

    localparam int               c_res_w   = 2 * OP_W;
    localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_last    = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    localparam logic [2:0] c_op_zero  = 3'd0;
    localparam logic [2:0] c_op_passa = 3'd1;
    localparam logic [2:0] c_op_passb = 3'd2;
    localparam logic [2:0] c_op_add   = 3'd3;
    localparam logic [2:0] c_op_sub   = 3'd4;
    localparam logic [2:0] c_op_mult  = 3'd5;
    localparam logic [2:0] c_op_div   = 3'd6;
    localparam logic [2:0] c_op_mod   = 3'd7;

    logic [2:0]         r_opc [DEPTH];
    logic [OP_W-1:0]    r_opa [DEPTH];
    logic [OP_W-1:0]    r_opb [DEPTH];
    logic [c_res_w-1:0] r_res [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_err;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    logic signed [c_res_w-1:0] w_ax;
    logic signed [c_res_w-1:0] w_bx;
    logic signed [c_res_w-1:0] w_res;
    logic                      w_err;
    logic                      w_b_zero;
    logic [PTR_W-1:0]          w_wr_idx;
    logic                      w_wr_ok;
    logic                      w_rd_ok;

    // Sign-extending to double width makes ADD/SUB/MULT and MIN/-1 exact.
    assign w_ax     = {{OP_W{operand_a[OP_W-1]}}, operand_a};
    assign w_bx     = {{OP_W{operand_b[OP_W-1]}}, operand_b};
    assign w_b_zero = (operand_b == '0);

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (opcode)
            c_op_zero:  w_res = '0;
            c_op_passa: w_res = w_ax;
            c_op_passb: w_res = w_bx;
            c_op_add:   w_res = w_ax + w_bx;
            c_op_sub:   w_res = w_ax - w_bx;
            c_op_mult:  w_res = w_ax * w_bx;
            c_op_div: begin
                if (w_b_zero) w_err = 1'b1;
                else          w_res = w_ax / w_bx;
            end
            c_op_mod: begin
                if (w_b_zero) w_err = 1'b1;
                else          w_res = w_ax % w_bx;
            end
            default:    w_res = '0;
        endcase
    end

    assign w_wr_idx = (AUTO_INC != 0) ? r_wr_ptr : write_pointer;
    assign w_wr_ok  = load_en && ({1'b0, w_wr_idx} < c_depth);
    assign w_rd_ok  = ({1'b0, read_pointer} < c_depth);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_opc[i] <= '0;
                r_opa[i] <= '0;
                r_opb[i] <= '0;
                r_res[i] <= '0;
            end
            r_valid  <= '0;
            r_err    <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_wr_ok) begin
            r_opc[w_wr_idx]   <= opcode;
            r_opa[w_wr_idx]   <= operand_a;
            r_opb[w_wr_idx]   <= operand_b;
            r_res[w_wr_idx]   <= w_res;
            r_valid[w_wr_idx] <= 1'b1;
            r_err[w_wr_idx]   <= w_err;
            if (!r_valid[w_wr_idx] && (r_count != c_depth))
                r_count <= r_count + c_cnt_one;
            if (AUTO_INC != 0)
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_one;
        end
    end

    // Registered read sees pre-write slot contents on a same-edge collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_opcode    <= '0;
            rd_operand_a <= '0;
            rd_operand_b <= '0;
            rd_result    <= '0;
            rd_valid     <= 1'b0;
            rd_err       <= 1'b0;
        end else if (w_rd_ok) begin
            rd_opcode    <= r_opc[read_pointer];
            rd_operand_a <= r_opa[read_pointer];
            rd_operand_b <= r_opb[read_pointer];
            rd_result    <= r_res[read_pointer];
            rd_valid     <= r_valid[read_pointer];
            rd_err       <= r_err[read_pointer];
        end else begin
            rd_opcode    <= '0;
            rd_operand_a <= '0;
            rd_operand_b <= '0;
            rd_result    <= '0;
            rd_valid     <= 1'b0;
            rd_err       <= 1'b0;
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign count  = r_count;
    assign full   = (r_count == c_depth);

endmodule
`default_nettype wire

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
- Parametrised next-generation instruction register: stores opcode and two signed operands per slot.
- Computes each instruction's result at write time and stores it alongside the instruction.
- Adds per-slot valid and error flags, an optional auto-incrementing write pointer, occupancy count, and registered read-out.
- Sits between the testbench interface and downstream checkers, which read pre-computed results by pointer.

Parameters:
- OP_W, 32, operand width in bits; operands are signed two's complement.
- DEPTH, 32, number of slots; need not be a power of two, must be at least 2.
- AUTO_INC, 1, 1 = internal write pointer; 0 = external write_pointer input.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write strobe.
- opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD.
- operand_a  in  OP_W  signed operand A.
- operand_b  in  OP_W  signed operand B.
- write_pointer  in  PTR_W  write slot; used only when AUTO_INC=0.
- read_pointer  in  PTR_W  read slot.
- rd_opcode  out  3  opcode of the read slot.
- rd_operand_a  out  OP_W  operand A of the read slot.
- rd_operand_b  out  OP_W  operand B of the read slot.
- rd_result  out  2*OP_W  stored signed result.
- rd_valid  out  1  read slot has been written since reset.
- rd_err  out  1  stored result is a divide-by-zero substitute.
- wr_ptr  out  PTR_W  current internal write pointer (0 when AUTO_INC=0).
- count  out  PTR_W+1  number of valid slots.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - All slots cleared: opcode 0, operands 0, result 0, valid 0, err 0.
  - All rd_* outputs 0; wr_ptr 0; count 0; full 0.
  - A write in the same cycle as reset is lost.
- Write, at the rising edge with load_en=1:
  - Target slot is wr_ptr if AUTO_INC=1, else write_pointer.
  - The slot captures opcode, operands, the computed result and err, and sets valid=1.
- Result arithmetic (combinational from inputs, sign-extended to 2*OP_W):
  - ZERO gives 0. PASSA gives A. PASSB gives B.
  - ADD gives A+B and SUB gives A-B, with no overflow possible at 2*OP_W.
  - MULT gives the full signed product A*B.
  - DIV gives A/B truncated toward zero. MOD gives A%B, whose sign follows A.
  - DIV or MOD with B=0: result 0, err=1. All other cases: err=0.
  - DIV of the most negative A by -1: the result is +2^(OP_W-1), representable at 2*OP_W, err=0.
- Auto-increment (AUTO_INC=1):
  - wr_ptr advances by 1 on every write and wraps from DEPTH-1 to 0.
  - Writes continue when full, overwriting the oldest slot.
- External pointer (AUTO_INC=0):
  - A write with write_pointer >= DEPTH is ignored; no state changes.
- Occupancy:
  - count increments only when a write targets a slot with valid=0.
  - Overwriting a valid slot leaves count unchanged.
  - count saturates at DEPTH; full is asserted combinationally from count.
- Read (registered, latency 1):
  - The rd_* outputs at edge N+1 reflect the slot addressed by read_pointer at edge N.
  - read_pointer >= DEPTH returns all zeros, with rd_valid=0.
- Read and write to the same slot on the same edge: read returns the pre-write contents (read-before-write). The new contents are visible one edge later.
- No stalls and no backpressure: one write per cycle, sustained.

Test Plan:
- Reset mid-stream: write 3 slots, assert reset between edges -> all rd_* 0, count 0, wr_ptr 0 immediately, before the next edge.
- AUTO_INC=1, DEPTH=4: 6 writes of ADD with A=i, B=1 -> wr_ptr 2, count 4, full 1; slot 0 holds result 5, slot 1 holds 6, slot 2 holds 3.
- Arithmetic, OP_W=8:
  - MULT -128*-128 -> 16384.
  - SUB -128-1 -> -129.
  - DIV -7/2 -> -3.
  - MOD -7%2 -> -1.
  - DIV -128/-1 -> 128.
  - DIV 5/0 -> result 0, rd_err 1.
- AUTO_INC=0, DEPTH=5:
  - Write to pointer 5 -> ignored, count stays 0.
  - Write to pointer 4 twice -> count 1.
  - Read pointer 7 -> rd_valid 0.
- Read latency and collision: read_pointer=2 while writing PASSA A=9 to slot 2 -> next edge shows old slot 2 data (0, rd_valid 0); the edge after shows 9, rd_valid 1.
- Back-to-back: 32 consecutive writes with random operands and opcodes 0-7 -> every slot read back matches the reference model, including err flags.
